// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared I2S constants, stereo sample type and slot bit selection
package i2s_pkg;

   localparam int WIDTH   = 24;
   localparam int SLOTS   = 32;
   localparam int BCK_DIV = 8;

   localparam int BC_W  = $clog2(BCK_DIV);
   localparam int BIT_W = $clog2(2 * SLOTS);
   localparam int W_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef struct packed {
      logic [WIDTH-1:0] left;
      logic [WIDTH-1:0] right;
   } stereo_t;

   // Philips framing: slot position k=0 is the delay bit, MSB at k=1, zero padding after the LSB.
   function automatic logic serial_bit(input stereo_t w, input logic [BIT_W-1:0] pos);
      logic [BIT_W-1:0] k;
      logic [WIDTH-1:0] word;
      logic [W_W-1:0]   idx;
      if (pos >= BIT_W'(SLOTS)) begin
         k    = pos - BIT_W'(SLOTS);
         word = w.right;
      end else begin
         k    = pos;
         word = w.left;
      end
      idx = W_W'(WIDTH - int'(k));
      serial_bit = (k != '0 && k <= BIT_W'(WIDTH)) ? word[idx] : 1'b0;
   endfunction

endpackage

// File: rtl/i2s_clkgen.sv
// rtl/i2s_clkgen.sv - I2S master clock generator: scki, bck, lrck and frame strobes
module i2s_clkgen
   import i2s_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   output logic             scki,
   output logic             bck,
   output logic             lrck,
   output logic             fall_tick,
   output logic             load_tick,
   output logic [BIT_W-1:0] bitcnt_next
);

   logic [BC_W-1:0]  bcnt;
   logic [BC_W-1:0]  bcnt_next;
   logic [BIT_W-1:0] bitcnt;

   assign fall_tick   = (bcnt == BC_W'(BCK_DIV - 1));
   assign load_tick   = fall_tick && (bitcnt == BIT_W'(2 * SLOTS - 1));
   assign bcnt_next   = fall_tick ? '0 : bcnt + 1'b1;
   assign bitcnt_next = (bitcnt == BIT_W'(2 * SLOTS - 1)) ? '0 : bitcnt + 1'b1;

   // bck and lrck are decoded from next-state values so they switch on the same edge as dout.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         scki   <= 1'b0;
         bcnt   <= '0;
         bitcnt <= '0;
         bck    <= 1'b0;
         lrck   <= 1'b0;
      end else begin
         scki <= ~scki;
         bcnt <= bcnt_next;
         bck  <= (bcnt_next >= BC_W'(BCK_DIV / 2));
         if (fall_tick) begin
            bitcnt <= bitcnt_next;
            lrck   <= (bitcnt_next >= BIT_W'(SLOTS));
         end
      end
   end

endmodule

// File: rtl/i2s_tx.sv
// rtl/i2s_tx.sv - I2S master transmitter: holding register, frame loader and serial data output
module i2s_tx
   import i2s_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] left,
   input  logic [WIDTH-1:0] right,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             dout,
   output logic             bck,
   output logic             lrck,
   output logic             scki,
   output logic             frame_start,
   output logic             underrun
);

   logic             fall_tick;
   logic             load_tick;
   logic [BIT_W-1:0] bitcnt_next;
   logic             hold_full;
   logic             accept;
   stereo_t          hold;
   stereo_t          shift;

   i2s_clkgen u_clkgen (
      .clk         (clk),
      .reset       (reset),
      .scki        (scki),
      .bck         (bck),
      .lrck        (lrck),
      .fall_tick   (fall_tick),
      .load_tick   (load_tick),
      .bitcnt_next (bitcnt_next)
   );

   // The holding register drains on load_tick, so a new pair may land in that same cycle.
   assign in_ready = !hold_full || load_tick;
   assign accept   = in_valid && in_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hold        <= '0;
         hold_full   <= 1'b0;
         shift       <= '0;
         dout        <= 1'b0;
         frame_start <= 1'b0;
         underrun    <= 1'b0;
      end else begin
         frame_start <= load_tick;
         underrun    <= load_tick && !hold_full;
         if (load_tick)
            shift <= hold_full ? hold : '0;
         if (accept) begin
            hold.left  <= left;
            hold.right <= right;
            hold_full  <= 1'b1;
         end else if (load_tick) begin
            hold_full <= 1'b0;
         end
         // Across a frame boundary bitcnt_next is 0, the delay slot, so the pre-load shifter is never sampled.
         if (fall_tick)
            dout <= serial_bit(shift, bitcnt_next);
      end
   end

endmodule
